// File: rtl/delay_scan_ctrl_if.sv
// Lane-side bundle between delay_scan_ctrl (master) and input_blocks (slave): tap load, counter clear and
// the lane's error/bit counters.
interface delay_scan_ctrl_if #(
  parameter int COUNTER_WIDTH = 32
);
  logic [COUNTER_WIDTH-1:0] error_counter;
  logic [COUNTER_WIDTH-1:0] bit_counter;
  logic                     delay_ready;
  logic                     delay_set;
  logic [8:0]               delay_in;
  logic                     reset_counters;

  modport master (
    input  error_counter, bit_counter, delay_ready,
    output delay_set, delay_in, reset_counters
  );

  modport slave (
    output error_counter, bit_counter, delay_ready,
    input  delay_set, delay_in, reset_counters
  );
endinterface

// File: rtl/delay_scan_ctrl.sv
// Eye-scan/centring controller for one input_blocks lane: sweeps IDELAY taps, tracks the longest good run and
// loads its centre tap. Define DELAY_SCAN_THRESH_EN to add a programmable error threshold (err_thresh).
module delay_scan_ctrl #(
  parameter int COUNTER_WIDTH  = 32,
  parameter int TAP_STEP       = 8,
  parameter int TAP_MAX        = 504,
  parameter int DWELL_BITS     = 65536,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int FALLBACK_TAP   = 256
) (
  input  logic                     clk160,
  input  logic                     rstb,
  input  logic                     scan_start,
`ifdef DELAY_SCAN_THRESH_EN
  input  logic [COUNTER_WIDTH-1:0] err_thresh,
`endif
  delay_scan_ctrl_if.master        lane,
  output logic                     busy,
  output logic                     done,
  output logic                     fail,
  output logic [8:0]               best_delay,
  output logic [8:0]               eye_width
);

  localparam logic [3:0] IDLE       = 4'd0;
  localparam logic [3:0] SET        = 4'd1;
  localparam logic [3:0] SETTLE     = 4'd2;
  localparam logic [3:0] WAIT_RDY   = 4'd3;
  localparam logic [3:0] CLR        = 4'd4;
  localparam logic [3:0] DWELL      = 4'd5;
  localparam logic [3:0] EVAL       = 4'd6;
  localparam logic [3:0] NEXT       = 4'd7;
  localparam logic [3:0] APPLY      = 4'd8;
  localparam logic [3:0] APPLY_WAIT = 4'd9;
  localparam logic [3:0] FINISH     = 4'd10;

  localparam int                       CNT_W        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]         SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]         TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] DWELL_LIM    = COUNTER_WIDTH'(DWELL_BITS);
  localparam logic [8:0]               STEP         = 9'(TAP_STEP);
  localparam logic [8:0]               TAP_LAST     = 9'(TAP_MAX);
  localparam logic [8:0]               FALLBACK     = 9'(FALLBACK_TAP);
  localparam int                       STEP_SH      = $clog2(TAP_STEP);

  logic [3:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             dwell_first;
  logic [8:0]       tap;
  logic [8:0]       cur_start;
  logic [8:0]       best_start;
  // Run lengths count scan points; 10 bits covers a full 512-point sweep at TAP_STEP 1.
  logic [9:0]       cur_len;
  logic [9:0]       best_len;
  logic [9:0]       half_len;
  logic [8:0]       centre;
  logic             tap_good;
  logic             dwell_met;
  logic             cur_wins;

`ifdef DELAY_SCAN_THRESH_EN
  logic [COUNTER_WIDTH-1:0] thresh_q;
  assign tap_good = (lane.error_counter <= thresh_q);
`else
  assign tap_good = (lane.error_counter == '0);
`endif

  assign dwell_met = (lane.bit_counter >= DWELL_LIM);
  // Strict compare keeps the earlier (lower-tap) run on a tie.
  assign cur_wins  = (cur_len > best_len);
  assign half_len  = (best_len - 10'd1) >> 1;
  assign centre    = best_start + 9'(half_len << STEP_SH);

  always_ff @(posedge clk160) begin
    if (!rstb) begin
      state               <= IDLE;
      cnt                 <= '0;
      dwell_first         <= 1'b0;
      tap                 <= '0;
      cur_start           <= '0;
      cur_len             <= '0;
      best_start          <= '0;
      best_len            <= '0;
      lane.delay_set      <= 1'b0;
      lane.delay_in       <= '0;
      lane.reset_counters <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
      fail                <= 1'b0;
      best_delay          <= '0;
      eye_width           <= '0;
`ifdef DELAY_SCAN_THRESH_EN
      thresh_q            <= '0;
`endif
    end else begin
      lane.delay_set      <= 1'b0;
      lane.reset_counters <= 1'b0;
      done                <= 1'b0;

      case (state)
        IDLE: begin
          if (scan_start) begin
            tap            <= '0;
            cur_start      <= '0;
            cur_len        <= '0;
            best_start     <= '0;
            best_len       <= '0;
            fail           <= 1'b0;
            busy           <= 1'b1;
            lane.delay_in  <= '0;
            lane.delay_set <= 1'b1;
`ifdef DELAY_SCAN_THRESH_EN
            thresh_q       <= err_thresh;
`endif
            state          <= SET;
          end
        end

        SET: begin
          cnt   <= '0;
          state <= SETTLE;
        end

        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= WAIT_RDY;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Timeout leaves best_delay and delay_in untouched.
        WAIT_RDY: begin
          if (lane.delay_ready) begin
            lane.reset_counters <= 1'b1;
            state               <= CLR;
          end else if (cnt == TIMEOUT_LAST) begin
            fail  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        CLR: begin
          cnt         <= '0;
          dwell_first <= 1'b1;
          state       <= DWELL;
        end

        // The first DWELL cycle still sees the pre-clear counters, so it is skipped.
        DWELL: begin
          dwell_first <= 1'b0;
          if (!dwell_first && dwell_met) begin
            state <= EVAL;
          end else if (cnt == TIMEOUT_LAST) begin
            fail  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        EVAL: begin
          if (tap_good) begin
            if (cur_len == '0) begin
              cur_start <= tap;
            end
            cur_len <= cur_len + 10'd1;
          end else begin
            if (cur_wins) begin
              best_start <= cur_start;
              best_len   <= cur_len;
            end
            cur_len <= '0;
          end
          state <= NEXT;
        end

        NEXT: begin
          if (tap < TAP_LAST) begin
            tap            <= tap + STEP;
            lane.delay_in  <= tap + STEP;
            lane.delay_set <= 1'b1;
            state          <= SET;
          end else begin
            // A run still open at TAP_MAX is closed here exactly as a bad tap would.
            if (cur_wins) begin
              best_start <= cur_start;
              best_len   <= cur_len;
            end
            cur_len <= '0;
            state   <= APPLY;
          end
        end

        APPLY: begin
          if (best_len != '0) begin
            best_delay    <= centre;
            lane.delay_in <= centre;
          end else begin
            best_delay    <= FALLBACK;
            lane.delay_in <= FALLBACK;
            fail          <= 1'b1;
          end
          eye_width      <= best_len[8:0];
          lane.delay_set <= 1'b1;
          cnt            <= '0;
          state          <= APPLY_WAIT;
        end

        APPLY_WAIT: begin
          if (cnt == SETTLE_LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // scan_start seen here (the done cycle) is dropped; IDLE accepts it next cycle.
        FINISH: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_scan_ctrl.sv
// Directed bench for delay_scan_ctrl: a behavioural lane model supplies counters whose error rate depends on
// the loaded tap; each task drives one scenario and checks the controller's results against hand-worked values.
module tb_delay_scan_ctrl;
  localparam int CW      = 32;
  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 4096;

  logic       clk160 = 1'b0;
  logic       rstb;
  logic       scan_start;
  logic       ready_en;
  logic       busy;
  logic       done;
  logic       fail;
  logic [8:0] best_delay;
  logic [8:0] eye_width;
`ifdef DELAY_SCAN_THRESH_EN
  logic [CW-1:0] err_thresh;
`endif

  int total = 0;
  int bad   = 0;
  int good_lo1 = 600, good_hi1 = 600, good_lo2 = 600, good_hi2 = 600;
  logic [8:0] lane_tap;
  int set_cnt = 0;
  int done_cnt = 0;
  logic [8:0] set_log[$];

  always #5 clk160 = ~clk160;

  delay_scan_ctrl_if #(.COUNTER_WIDTH(CW)) lane ();

  delay_scan_ctrl dut (
    .clk160     (clk160),
    .rstb       (rstb),
    .scan_start (scan_start),
`ifdef DELAY_SCAN_THRESH_EN
    .err_thresh (err_thresh),
`endif
    .lane       (lane),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .best_delay (best_delay),
    .eye_width  (eye_width)
  );

  function automatic bit tap_is_good(input logic [8:0] t);
    int ti;
    ti = int'(t);
    return (ti >= good_lo1 && ti <= good_hi1) || (ti >= good_lo2 && ti <= good_hi2);
  endfunction

  // Lane model: 16384 bits per cycle, one error per cycle on a bad tap, counters cleared by reset_counters.
  assign lane.delay_ready = ready_en;
  always @(posedge clk160) begin
    if (!rstb) begin
      lane_tap           <= '0;
      lane.bit_counter   <= '0;
      lane.error_counter <= '0;
    end else begin
      if (lane.delay_set) lane_tap <= lane.delay_in;
      if (lane.reset_counters) begin
        lane.bit_counter   <= '0;
        lane.error_counter <= '0;
      end else begin
        lane.bit_counter <= lane.bit_counter + 32'd16384;
        if (!tap_is_good(lane_tap)) lane.error_counter <= lane.error_counter + 32'd1;
      end
    end
  end

  always @(negedge clk160) begin
    if (lane.delay_set) begin
      set_cnt++;
      set_log.push_back(lane.delay_in);
    end
    if (done) done_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk160);
  endtask

  // Pulses scan_start and returns the cycle (1 = SET cycle) in which done is seen, or -1 past the budget.
  task automatic run_scan(input int budget, output int lat);
    lat = -1;
    scan_start = 1'b1;
    @(negedge clk160);
    scan_start = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk160);
    end
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    tick(3);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (fail !== 1'b0) begin bad++; $display("FAIL reset_fail: got %b want 0", fail); end
    total++; if (best_delay !== 9'd0) begin bad++; $display("FAIL reset_best_delay: got %0d want 0", best_delay); end
    total++; if (eye_width !== 9'd0) begin bad++; $display("FAIL reset_eye_width: got %0d want 0", eye_width); end
    total++; if (lane.delay_set !== 1'b0 || lane.reset_counters !== 1'b0)
      begin bad++; $display("FAIL reset_strobes: got set=%b clr=%b want 0 0", lane.delay_set, lane.reset_counters); end
    total++; if (lane.delay_in !== 9'd0) begin bad++; $display("FAIL reset_delay_in: got %0d want 0", lane.delay_in); end
    rstb = 1'b1;
    tick(2);
  endtask

  task automatic test_clean_eye();
    int lat, s0, d0;
    good_lo1 = 64; good_hi1 = 192; good_lo2 = 600; good_hi2 = 600;
    s0 = set_cnt; d0 = done_cnt;
    run_scan(5000, lat);
    tick(4);
    // 64 points x 26 cycles (1+16+1+1+5+2), then APPLY 1 + APPLY_WAIT 16, done in the next cycle.
    total++; if (lat !== 1682) begin bad++; $display("FAIL clean_latency: got %0d want 1682", lat); end
    total++; if (best_delay !== 9'd128) begin bad++; $display("FAIL clean_best_delay: got %0d want 128", best_delay); end
    total++; if (eye_width !== 9'd17) begin bad++; $display("FAIL clean_eye_width: got %0d want 17", eye_width); end
    total++; if (fail !== 1'b0) begin bad++; $display("FAIL clean_fail: got %b want 0", fail); end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL clean_done_pulses: got %0d want 1", done_cnt - d0); end
    total++; if (set_cnt - s0 !== 65) begin bad++; $display("FAIL clean_set_count: got %0d want 65", set_cnt - s0); end
    total++; if (set_log[set_log.size()-1] !== 9'd128)
      begin bad++; $display("FAIL clean_final_set: got %0d want 128", set_log[set_log.size()-1]); end
  endtask

  task automatic test_start_filter();
    int s0, d0, taps_bad;
    bit seen;
    good_lo1 = 64; good_hi1 = 192; good_lo2 = 600; good_hi2 = 600;
    s0 = set_cnt; d0 = done_cnt;
    scan_start = 1'b1; @(negedge clk160); scan_start = 1'b0;
    for (int k = 0; k < 200 && (set_cnt - s0) < 3; k++) @(negedge clk160);
    scan_start = 1'b1; @(negedge clk160); scan_start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk160);
    end
    // Start request landing in the done cycle must be dropped.
    scan_start = 1'b1; @(negedge clk160); scan_start = 1'b0;
    tick(30);
    total++; if (!seen) begin bad++; $display("FAIL filter_done: got no done want done within 5000 cycles"); end
    total++; if (set_cnt - s0 !== 65) begin bad++; $display("FAIL filter_set_count: got %0d want 65", set_cnt - s0); end
    taps_bad = 0;
    if (set_log.size() >= s0 + 64) begin
      for (int i = 0; i < 64; i++) if (set_log[s0+i] !== 9'(i * 8)) taps_bad++;
    end else begin
      taps_bad = 64;
    end
    total++; if (taps_bad !== 0) begin bad++; $display("FAIL filter_tap_sequence: got %0d wrong taps want 0", taps_bad); end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL filter_done_pulses: got %0d want 1", done_cnt - d0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL filter_start_in_done_cycle busy: got %b want 0", busy); end
    total++; if (best_delay !== 9'd128) begin bad++; $display("FAIL filter_best_delay: got %0d want 128", best_delay); end
  endtask

  task automatic test_equal_runs();
    int lat;
    // Two five-point runs on the 8-tap grid: 16..48 and 296..328.
    good_lo1 = 16; good_hi1 = 48; good_lo2 = 296; good_hi2 = 328;
    run_scan(5000, lat);
    tick(2);
    total++; if (lat < 0) begin bad++; $display("FAIL equal_done: got no done want done"); end
    total++; if (best_delay !== 9'd32) begin bad++; $display("FAIL equal_best_delay: got %0d want 32", best_delay); end
    total++; if (eye_width !== 9'd5) begin bad++; $display("FAIL equal_eye_width: got %0d want 5", eye_width); end
    total++; if (fail !== 1'b0) begin bad++; $display("FAIL equal_fail: got %b want 0", fail); end
  endtask

  task automatic test_no_good();
    int lat, d0;
    good_lo1 = 600; good_hi1 = 600; good_lo2 = 600; good_hi2 = 600;
    d0 = done_cnt;
    run_scan(5000, lat);
    tick(2);
    total++; if (lat < 0 || done_cnt - d0 !== 1) begin bad++; $display("FAIL nogood_done: got lat=%0d pulses=%0d want one done", lat, done_cnt - d0); end
    total++; if (best_delay !== 9'd256) begin bad++; $display("FAIL nogood_best_delay: got %0d want 256", best_delay); end
    total++; if (eye_width !== 9'd0) begin bad++; $display("FAIL nogood_eye_width: got %0d want 0", eye_width); end
    total++; if (fail !== 1'b1) begin bad++; $display("FAIL nogood_fail: got %b want 1", fail); end
    total++; if (lane.delay_in !== 9'd256) begin bad++; $display("FAIL nogood_delay_in: got %0d want 256", lane.delay_in); end
  endtask

  task automatic test_top_run();
    int lat;
    good_lo1 = 480; good_hi1 = 504; good_lo2 = 600; good_hi2 = 600;
    run_scan(5000, lat);
    tick(2);
    total++; if (lat < 0) begin bad++; $display("FAIL top_done: got no done want done"); end
    total++; if (best_delay !== 9'd488) begin bad++; $display("FAIL top_best_delay: got %0d want 488", best_delay); end
    total++; if (eye_width !== 9'd4) begin bad++; $display("FAIL top_eye_width: got %0d want 4", eye_width); end
    total++; if (fail !== 1'b0) begin bad++; $display("FAIL top_fail: got %b want 0", fail); end
  endtask

  task automatic test_timeout();
    int lat, s0;
    ready_en = 1'b0;
    s0 = set_cnt;
    run_scan(TIMEOUT + 200, lat);
    tick(50);
    // SET(1) + SETTLE + TIMEOUT cycles in WAIT_RDY, done in the following cycle.
    total++; if (lat !== 2 + SETTLE + TIMEOUT) begin bad++; $display("FAIL timeout_latency: got %0d want %0d", lat, 2 + SETTLE + TIMEOUT); end
    total++; if (fail !== 1'b1) begin bad++; $display("FAIL timeout_fail: got %b want 1", fail); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL timeout_busy: got %b want 0", busy); end
    total++; if (best_delay !== 9'd488) begin bad++; $display("FAIL timeout_best_delay: got %0d want 488", best_delay); end
    total++; if (lane.delay_in !== 9'd0) begin bad++; $display("FAIL timeout_delay_in: got %0d want 0", lane.delay_in); end
    total++; if (set_cnt - s0 !== 1) begin bad++; $display("FAIL timeout_set_count: got %0d want 1", set_cnt - s0); end
    ready_en = 1'b1;
  endtask

  task automatic test_reset_mid_scan();
    int clears;
    good_lo1 = 480; good_hi1 = 504; good_lo2 = 600; good_hi2 = 600;
    scan_start = 1'b1; @(negedge clk160); scan_start = 1'b0;
    clears = 0;
    for (int k = 0; k < 300 && clears < 3; k++) begin
      @(negedge clk160);
      if (lane.reset_counters) clears++;
    end
    tick(2);
    total++; if (clears !== 3 || busy !== 1'b1) begin bad++; $display("FAIL midreset_in_dwell: got clears=%0d busy=%b want 3 1", clears, busy); end
    rstb = 1'b0;
    @(negedge clk160);
    total++; if (busy !== 1'b0 || done !== 1'b0 || fail !== 1'b0)
      begin bad++; $display("FAIL midreset_flags: got busy=%b done=%b fail=%b want 0 0 0", busy, done, fail); end
    total++; if (best_delay !== 9'd0 || eye_width !== 9'd0)
      begin bad++; $display("FAIL midreset_results: got best=%0d width=%0d want 0 0", best_delay, eye_width); end
    total++; if (lane.delay_in !== 9'd0) begin bad++; $display("FAIL midreset_delay_in: got %0d want 0", lane.delay_in); end
    total++; if (lane.delay_set !== 1'b0 || lane.reset_counters !== 1'b0)
      begin bad++; $display("FAIL midreset_strobes: got set=%b clr=%b want 0 0", lane.delay_set, lane.reset_counters); end
    rstb = 1'b1;
    tick(30);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_no_restart: got busy=%b want 0", busy); end
  endtask

  initial begin
    rstb       = 1'b0;
    scan_start = 1'b0;
    ready_en   = 1'b1;
`ifdef DELAY_SCAN_THRESH_EN
    err_thresh = '0;
`endif
    test_reset();
    test_clean_eye();
    test_start_filter();
    test_equal_runs();
    test_no_good();
    test_top_run();
    test_timeout();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
